// File: rtl/reg_decode.sv
// DLX instruction-decode stage: 32x32 register file written on the falling edge,
// decoded controls and operands captured into the ID/EX register on the rising edge.
module reg_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction_i,
    input  logic [31:0] delay_i,
    input  logic [31:0] delay2_i,
    input  logic [4:0]  rw_i,
    input  logic [31:0] bus_w_i,
    input  logic        wrenable_i,
    output logic [31:0] delayout_o,
    output logic [31:0] delay2out_o,
    output logic [31:0] imm16_o,
    output logic [31:0] bus_a_o,
    output logic [31:0] bus_b_o,
    output logic        regdst_o,
    output logic        alusrc_o,
    output logic        mem2reg_o,
    output logic        regwrite_o,
    output logic        memwrite_o,
    output logic        branch_o,
    output logic        jump_o,
    output logic [3:0]  aluctrl_o,
    output logic [1:0]  fpoint_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs2_o,
    output logic [1:0]  dsize_o,
    output logic        loadext_o,
    output logic        jal_o,
    output logic        jar_o
);

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       mem2reg;
        logic       regwrite;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic [3:0] aluctrl;
        logic [1:0] fpoint;
        logic [1:0] dsize;
        logic       loadext;
        logic       jal;
        logic       jar;
    } ctrl_t;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpMul   = 6'h01;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeqz  = 6'h04;
    localparam logic [5:0] OpBnez  = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddui = 6'h09;
    localparam logic [5:0] OpSubi  = 6'h0A;
    localparam logic [5:0] OpSubui = 6'h0B;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLhi   = 6'h0F;
    localparam logic [5:0] OpJr    = 6'h12;
    localparam logic [5:0] OpJalr  = 6'h13;
    localparam logic [5:0] OpSlli  = 6'h14;
    localparam logic [5:0] OpSrli  = 6'h16;
    localparam logic [5:0] OpSrai  = 6'h17;
    localparam logic [5:0] OpSeqi  = 6'h18;
    localparam logic [5:0] OpSnei  = 6'h19;
    localparam logic [5:0] OpSlti  = 6'h1A;
    localparam logic [5:0] OpSgti  = 6'h1B;
    localparam logic [5:0] OpSlei  = 6'h1C;
    localparam logic [5:0] OpSgei  = 6'h1D;
    localparam logic [5:0] OpLb    = 6'h20;
    localparam logic [5:0] OpLh    = 6'h21;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpLbu   = 6'h24;
    localparam logic [5:0] OpLhu   = 6'h25;
    localparam logic [5:0] OpSb    = 6'h28;
    localparam logic [5:0] OpSh    = 6'h29;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnMult  = 6'h0E;
    localparam logic [5:0] FnMultu = 6'h16;

    localparam logic [3:0] AluAdd   = 4'b0000;
    localparam logic [3:0] AluSub   = 4'b0001;
    localparam logic [3:0] AluAnd   = 4'b0010;
    localparam logic [3:0] AluOr    = 4'b0011;
    localparam logic [3:0] AluXor   = 4'b0100;
    localparam logic [3:0] AluSll   = 4'b0101;
    localparam logic [3:0] AluSrl   = 4'b0110;
    localparam logic [3:0] AluSra   = 4'b0111;
    localparam logic [3:0] AluPassB = 4'b1110;
    localparam logic [3:0] AluMul   = 4'b1111;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    logic [31:0] regs_q [32];

    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] sext16;
    logic [31:0] zext16;
    logic [31:0] sext26;

    ctrl_t       ctrl_d, ctrl_q;
    logic [31:0] imm_d, imm_q;
    logic [4:0]  rd_d, rd_q;
    logic [31:0] bus_a_d, bus_a_q;
    logic [31:0] bus_b_d, bus_b_q;
    logic [31:0] delay_q, delay2_q;
    logic [4:0]  rs2_q;

    assign opcode  = instruction_i[31:26];
    assign func    = instruction_i[5:0];
    assign rs1_idx = instruction_i[25:21];
    assign rs2_idx = instruction_i[20:16];
    assign sext16  = {{16{instruction_i[15]}}, instruction_i[15:0]};
    assign zext16  = {16'h0000, instruction_i[15:0]};
    assign sext26  = {{6{instruction_i[25]}}, instruction_i[25:0]};

    // Falling-edge write so a same-cycle read sees the new value at the next rising edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wrenable_i && (rw_i != 5'd0)) begin
            regs_q[rw_i] <= bus_w_i;
        end
    end

    assign bus_a_d = (rs1_idx == 5'd0) ? 32'h0 : regs_q[rs1_idx];
    assign bus_b_d = (rs2_idx == 5'd0) ? 32'h0 : regs_q[rs2_idx];

    always_comb begin
        ctrl_d = '0;
        imm_d  = sext16;
        case (opcode)
            OpRtype: begin
                ctrl_d.regdst   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                case (func)
                    6'h04:        ctrl_d.aluctrl = AluSll;
                    6'h06:        ctrl_d.aluctrl = AluSrl;
                    6'h07:        ctrl_d.aluctrl = AluSra;
                    6'h20, 6'h21: ctrl_d.aluctrl = AluAdd;
                    6'h22, 6'h23: ctrl_d.aluctrl = AluSub;
                    6'h24:        ctrl_d.aluctrl = AluAnd;
                    6'h25:        ctrl_d.aluctrl = AluOr;
                    6'h26:        ctrl_d.aluctrl = AluXor;
                    6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D:
                        ctrl_d.aluctrl = {1'b1, func[2:0]};
                    default:      ctrl_d = '0;
                endcase
            end
            OpMul: begin
                ctrl_d.regdst = 1'b1;
                case (func)
                    FnMult: begin
                        ctrl_d.fpoint   = 2'b01;
                        ctrl_d.aluctrl  = AluMul;
                        ctrl_d.regwrite = 1'b1;
                    end
                    FnMultu: begin
                        ctrl_d.fpoint   = 2'b10;
                        ctrl_d.aluctrl  = AluMul;
                        ctrl_d.regwrite = 1'b1;
                    end
                    default: ctrl_d.fpoint = 2'b11;
                endcase
            end
            OpJ: begin
                ctrl_d.jump = 1'b1;
                imm_d       = sext26;
            end
            OpJal: begin
                ctrl_d.jump     = 1'b1;
                ctrl_d.jal      = 1'b1;
                ctrl_d.regwrite = 1'b1;
                imm_d           = sext26;
            end
            OpJr: begin
                ctrl_d.jump = 1'b1;
                ctrl_d.jar  = 1'b1;
            end
            OpJalr: begin
                ctrl_d.jump     = 1'b1;
                ctrl_d.jar      = 1'b1;
                ctrl_d.jal      = 1'b1;
                ctrl_d.regwrite = 1'b1;
            end
            OpBeqz, OpBnez: ctrl_d.branch = 1'b1;
            OpAddi, OpSubi: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                ctrl_d.aluctrl  = (opcode == OpSubi) ? AluSub : AluAdd;
            end
            OpAddui, OpSubui, OpAndi, OpOri, OpXori, OpSlli, OpSrli, OpSrai: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                imm_d           = zext16;
                unique case (opcode)
                    OpAddui: ctrl_d.aluctrl = AluAdd;
                    OpSubui: ctrl_d.aluctrl = AluSub;
                    OpAndi:  ctrl_d.aluctrl = AluAnd;
                    OpOri:   ctrl_d.aluctrl = AluOr;
                    OpXori:  ctrl_d.aluctrl = AluXor;
                    OpSlli:  ctrl_d.aluctrl = AluSll;
                    OpSrli:  ctrl_d.aluctrl = AluSrl;
                    default: ctrl_d.aluctrl = AluSra;
                endcase
            end
            OpLhi: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                ctrl_d.aluctrl  = AluPassB;
                imm_d           = {instruction_i[15:0], 16'h0000};
            end
            OpSeqi, OpSnei, OpSlti, OpSgti, OpSlei, OpSgei: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                ctrl_d.aluctrl  = {1'b1, opcode[2:0]};
            end
            OpLb, OpLh, OpLw, OpLbu, OpLhu: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                ctrl_d.mem2reg  = 1'b1;
                ctrl_d.loadext  = (opcode == OpLb) || (opcode == OpLh);
                if ((opcode == OpLb) || (opcode == OpLbu)) begin
                    ctrl_d.dsize = SizeByte;
                end else if ((opcode == OpLh) || (opcode == OpLhu)) begin
                    ctrl_d.dsize = SizeHalf;
                end else begin
                    ctrl_d.dsize = SizeWord;
                end
            end
            OpSb, OpSh, OpSw: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memwrite = 1'b1;
                if (opcode == OpSb) begin
                    ctrl_d.dsize = SizeByte;
                end else if (opcode == OpSh) begin
                    ctrl_d.dsize = SizeHalf;
                end else begin
                    ctrl_d.dsize = SizeWord;
                end
            end
            default: ;
        endcase
    end

    // Links always target r31, overriding the format-selected destination.
    always_comb begin
        if (ctrl_d.jal) begin
            rd_d = 5'd31;
        end else if (ctrl_d.regdst) begin
            rd_d = instruction_i[15:11];
        end else begin
            rd_d = instruction_i[20:16];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            imm_q    <= '0;
            rd_q     <= '0;
            rs2_q    <= '0;
            bus_a_q  <= '0;
            bus_b_q  <= '0;
            delay_q  <= '0;
            delay2_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            imm_q    <= imm_d;
            rd_q     <= rd_d;
            rs2_q    <= rs2_idx;
            bus_a_q  <= bus_a_d;
            bus_b_q  <= bus_b_d;
            delay_q  <= delay_i;
            delay2_q <= delay2_i;
        end
    end

    assign delayout_o  = delay_q;
    assign delay2out_o = delay2_q;
    assign imm16_o     = imm_q;
    assign bus_a_o     = bus_a_q;
    assign bus_b_o     = bus_b_q;
    assign regdst_o    = ctrl_q.regdst;
    assign alusrc_o    = ctrl_q.alusrc;
    assign mem2reg_o   = ctrl_q.mem2reg;
    assign regwrite_o  = ctrl_q.regwrite;
    assign memwrite_o  = ctrl_q.memwrite;
    assign branch_o    = ctrl_q.branch;
    assign jump_o      = ctrl_q.jump;
    assign aluctrl_o   = ctrl_q.aluctrl;
    assign fpoint_o    = ctrl_q.fpoint;
    assign rd_o        = rd_q;
    assign rs2_o       = rs2_q;
    assign dsize_o     = ctrl_q.dsize;
    assign loadext_o   = ctrl_q.loadext;
    assign jal_o       = ctrl_q.jal;
    assign jar_o       = ctrl_q.jar;

endmodule

// File: tb/tb_reg_decode.sv
// Scoreboarded bench for reg_decode: directed and random instructions checked
// against a rule-table reference model of the decode stage.
module tb_reg_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] delay = '0;
    logic [31:0] delay2 = '0;
    logic [4:0]  rw = '0;
    logic [31:0] bus_w = '0;
    logic        wrenable = 1'b0;

    logic [31:0] delayout, delay2out, imm16, bus_a, bus_b;
    logic        regdst, alusrc, mem2reg, regwrite, memwrite, branch, jump;
    logic [3:0]  aluctrl;
    logic [1:0]  fpoint;
    logic [4:0]  rd, rs2;
    logic [1:0]  dsize;
    logic        loadext, jal, jar;

    typedef struct packed {
        logic [31:0] delayout;
        logic [31:0] delay2out;
        logic [31:0] imm16;
        logic [31:0] bus_a;
        logic [31:0] bus_b;
        logic        regdst;
        logic        alusrc;
        logic        mem2reg;
        logic        regwrite;
        logic        memwrite;
        logic        branch;
        logic        jump;
        logic [3:0]  aluctrl;
        logic [1:0]  fpoint;
        logic [4:0]  rd;
        logic [4:0]  rs2;
        logic [1:0]  dsize;
        logic        loadext;
        logic        jal;
        logic        jar;
    } resp_t;

    resp_t       act;
    resp_t       exp_q[$];
    logic [31:0] ref_regs [32];
    int          ralu [64];
    int          ialu [64];
    int          checks = 0;
    int          failures = 0;
    int          nresp = 0;

    reg_decode dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instruction_i(instruction),
        .delay_i      (delay),
        .delay2_i     (delay2),
        .rw_i         (rw),
        .bus_w_i      (bus_w),
        .wrenable_i   (wrenable),
        .delayout_o   (delayout),
        .delay2out_o  (delay2out),
        .imm16_o      (imm16),
        .bus_a_o      (bus_a),
        .bus_b_o      (bus_b),
        .regdst_o     (regdst),
        .alusrc_o     (alusrc),
        .mem2reg_o    (mem2reg),
        .regwrite_o   (regwrite),
        .memwrite_o   (memwrite),
        .branch_o     (branch),
        .jump_o       (jump),
        .aluctrl_o    (aluctrl),
        .fpoint_o     (fpoint),
        .rd_o         (rd),
        .rs2_o        (rs2),
        .dsize_o      (dsize),
        .loadext_o    (loadext),
        .jal_o        (jal),
        .jar_o        (jar)
    );

    always #5 clk = ~clk;

    assign act = {delayout, delay2out, imm16, bus_a, bus_b, regdst, alusrc, mem2reg, regwrite,
                  memwrite, branch, jump, aluctrl, fpoint, rd, rs2, dsize, loadext, jal, jar};

    function automatic resp_t predict(input logic [31:0] ins, input logic [31:0] d1,
                                      input logic [31:0] d2);
        resp_t r;
        logic [5:0] op, fn;
        bit is_r, is_fp, is_mul, alu_i, lhi, load, store, br, jmp, link, jreg;
        r      = '0;
        op     = ins[31:26];
        fn     = ins[5:0];
        is_r   = (op == 6'h00) && (ralu[fn] >= 0);
        is_fp  = (op == 6'h01);
        is_mul = is_fp && (fn == 6'h0E || fn == 6'h16);
        alu_i  = op inside {[6'h08:6'h0E], 6'h14, 6'h16, 6'h17, [6'h18:6'h1D]};
        lhi    = (op == 6'h0F);
        load   = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        store  = op inside {6'h28, 6'h29, 6'h2B};
        br     = op inside {6'h04, 6'h05};
        jmp    = op inside {6'h02, 6'h03, 6'h12, 6'h13};
        link   = op inside {6'h03, 6'h13};
        jreg   = op inside {6'h12, 6'h13};

        r.delayout  = d1;
        r.delay2out = d2;
        r.bus_a     = ref_regs[ins[25:21]];
        r.bus_b     = ref_regs[ins[20:16]];
        r.rs2       = ins[20:16];
        r.regdst    = is_r || is_fp;
        r.alusrc    = alu_i || lhi || load || store;
        r.regwrite  = is_r || is_mul || alu_i || lhi || load || link;
        r.mem2reg   = load;
        r.memwrite  = store;
        r.branch    = br;
        r.jump      = jmp;
        r.jal       = link;
        r.jar       = jreg;
        r.loadext   = op inside {6'h20, 6'h21};

        if (!is_fp)             r.fpoint = 2'd0;
        else if (fn == 6'h0E)   r.fpoint = 2'd1;
        else if (fn == 6'h16)   r.fpoint = 2'd2;
        else                    r.fpoint = 2'd3;

        if (is_r)                 r.aluctrl = 4'(ralu[fn]);
        else if (is_mul)          r.aluctrl = 4'hF;
        else if (alu_i || lhi)    r.aluctrl = 4'(ialu[op]);
        else                      r.aluctrl = 4'h0;

        if (op inside {6'h21, 6'h25, 6'h29})  r.dsize = 2'd1;
        else if (op inside {6'h23, 6'h2B})    r.dsize = 2'd2;
        else                                  r.dsize = 2'd0;

        if (link)          r.rd = 5'd31;
        else if (r.regdst) r.rd = ins[15:11];
        else               r.rd = ins[20:16];

        if (op inside {6'h02, 6'h03})
            r.imm16 = {{6{ins[25]}}, ins[25:0]};
        else if (lhi)
            r.imm16 = {ins[15:0], 16'h0000};
        else if (op inside {6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h14, 6'h16, 6'h17})
            r.imm16 = {16'h0000, ins[15:0]};
        else
            r.imm16 = {{16{ins[15]}}, ins[15:0]};
        return r;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [4:0] w_rw, input logic [31:0] w_bus, input logic w_en);
        @(posedge clk);
        #2;
        instruction = ins;
        delay       = d1;
        delay2      = d2;
        rw          = w_rw;
        bus_w       = w_bus;
        wrenable    = w_en;
        if (w_en && w_rw != 5'd0) ref_regs[w_rw] = w_bus;
        exp_q.push_back(predict(ins, d1, d2));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [33] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                                 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h12, 6'h13, 6'h14, 6'h16,
                                 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D, 6'h20, 6'h21,
                                 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
        logic [5:0] fns [18] = '{6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                 6'h26, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D, 6'h0E, 6'h16};
        logic [31:0] ins;
        logic [5:0]  op;
        ins = $urandom;
        if ($urandom_range(0, 9) == 0) op = 6'($urandom);
        else                           op = ops[$urandom_range(0, 32)];
        ins[31:26] = op;
        if ($urandom_range(0, 3) != 0) begin
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            ins[15:11] = 5'($urandom_range(0, 7));
        end
        if (op <= 6'h01 && $urandom_range(0, 7) != 0) ins[5:0] = fns[$urandom_range(0, 17)];
        return ins;
    endfunction

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            drive(rand_instr(), $urandom, $urandom, 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)));
        end
    endtask

    // Monitor: one response per rising edge while a prediction is outstanding.
    initial begin : monitor
        resp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL resp%0d ins-out got=%h want=%h", nresp, act, e);
                end
                nresp++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        for (int i = 0; i < 64; i++) begin
            ralu[i] = -1;
            ialu[i] = 0;
        end
        ralu[6'h04] = 5;  ralu[6'h06] = 6;  ralu[6'h07] = 7;
        ralu[6'h20] = 0;  ralu[6'h21] = 0;  ralu[6'h22] = 1;  ralu[6'h23] = 1;
        ralu[6'h24] = 2;  ralu[6'h25] = 3;  ralu[6'h26] = 4;
        ialu[6'h0A] = 1;  ialu[6'h0B] = 1;  ialu[6'h0C] = 2;  ialu[6'h0D] = 3;
        ialu[6'h0E] = 4;  ialu[6'h0F] = 14; ialu[6'h14] = 5;  ialu[6'h16] = 6;
        ialu[6'h17] = 7;
        for (int i = 0; i < 6; i++) begin
            ralu[6'h28 + i] = 8 + i;
            ialu[6'h18 + i] = 8 + i;
        end
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;

        #3;
        checks++;
        if (act !== '0) begin
            failures++;
            $display("FAIL reset_init got=%h want=0", act);
        end
        #9;
        rst_n = 1'b1;

        rand_phase(120);
        drive(32'h00220820, 32'h1234, 32'h5678, 5'd1, 32'hDEADBEEF, 1'b1);

        // Mid-cycle reset with nonzero outputs and r1 holding data.
        @(posedge clk);
        #3;
        wrenable = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++;
        if (act !== '0) begin
            failures++;
            $display("FAIL reset_async got=%h want=0", act);
        end
        exp_q.delete();
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        drive(32'h24210000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        drive(32'h00620820, 32'd1, 32'd2, 5'd1, 32'd1, 1'b1);
        drive(32'h24210000, 32'd3, 32'd4, 5'd0, 32'h0, 1'b0);
        drive(32'h14410000, 32'd5, 32'd6, 5'd2, 32'd2, 1'b1);
        drive(32'h3C410013, 32'd7, 32'd8, 5'd5, 32'd5, 1'b1);
        drive(32'h6C450022, 32'd9, 32'd10, 5'd0, 32'h0, 1'b0);
        drive(32'h24000000, 32'd11, 32'd12, 5'd0, 32'd7, 1'b1);
        drive(32'h4C400000, 32'd13, 32'd14, 5'd0, 32'h0, 1'b0);
        drive(32'h54000000, 32'd15, 32'd16, 5'd0, 32'h0, 1'b0);
        drive(32'h0C000ABC, 32'd17, 32'd18, 5'd0, 32'h0, 1'b0);
        drive(32'h08FFFFFF, 32'd19, 32'd20, 5'd0, 32'h0, 1'b0);

        rand_phase(200);

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
